// File: rtl/ip_pkg.sv
// Shared constants for the IPv4 receive path: protocol numbers, drop codes,
// FSM state encodings and the ones-complement adder used by the header checksum.
package ip_pkg;

   localparam logic [7:0] IPV4_PROTO_UDP = 8'd17;

   localparam logic [2:0] DROP_NONE  = 3'd0;
   localparam logic [2:0] DROP_VER   = 3'd1;
   localparam logic [2:0] DROP_PROTO = 3'd2;
   localparam logic [2:0] DROP_ADDR  = 3'd3;
   localparam logic [2:0] DROP_FRAG  = 3'd4;
   localparam logic [2:0] DROP_LEN   = 3'd5;
   localparam logic [2:0] DROP_CSUM  = 3'd6;
   localparam logic [2:0] DROP_TRUNC = 3'd7;

   localparam logic [1:0] ST_HDR     = 2'd0;
   localparam logic [1:0] ST_OPT     = 2'd1;
   localparam logic [1:0] ST_PAYLOAD = 2'd2;
   localparam logic [1:0] ST_DROP    = 2'd3;

   // 16-bit add with end-around carry; a single fold cannot overflow again.
   function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Ones-complement accumulator over a byte stream: even bytes are held as the
// high half of a big-endian word, odd bytes complete the word and add it in.
module ip_csum_acc
   import ip_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        en,
   input  logic        odd,
   input  logic [7:0]  byte_in,
   output logic [15:0] sum_out
);

   logic [15:0] sum_q;
   logic [7:0]  hi_q;
   logic [15:0] sum_nxt;

   assign sum_nxt = ones_add16(sum_q, {hi_q, byte_in});
   // Includes the word completed this cycle so the decision byte sees the full sum.
   assign sum_out = (en && odd) ? sum_nxt : sum_q;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         sum_q <= 16'h0000;
         hi_q  <= 8'h00;
      end else if (en) begin
         if (odd) sum_q <= sum_nxt;
         else     hi_q  <= byte_in;
      end
   end

endmodule

// File: rtl/ipv4_rcv.sv
// IPv4 receive stage: parses and validates the header, then forwards only the
// IP payload to udp_rcv, discarding Ethernet pad and rejected packets.
module ipv4_rcv
   import ip_pkg::*;
#(
   parameter logic [31:0] LOCAL_IP     = 32'hC0A8_0A02,
   parameter bit          ACCEPT_BCAST = 1'b1,
   parameter bit          CHECK_CSUM   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  ip_axis_tdata_in,
   input  logic        ip_axis_tvalid_in,
   input  logic        ip_axis_tlast_in,
   output logic        ip_axis_tready_out,
   output logic [7:0]  udp_axis_tdata_out,
   output logic        udp_axis_tvalid_out,
   output logic        udp_axis_tlast_out,
   input  logic        udp_axis_tready_in,
   output logic [31:0] src_ip_out,
   output logic [15:0] payload_len_out,
   output logic        pkt_ok_out,
   output logic        drop_out,
   output logic [2:0]  drop_code_out,
   output logic [15:0] drop_cnt_out
);

   logic [1:0]  state_q, state_d;
   logic [5:0]  hdr_cnt_q, hdr_cnt_d;
   logic [7:0]  ver_ihl_q, ver_ihl_d;
   logic [15:0] tot_len_q, tot_len_d;
   logic        mf_q, mf_d;
   logic [12:0] frag_off_q, frag_off_d;
   logic [7:0]  proto_q, proto_d;
   logic [31:0] src_hdr_q, src_hdr_d;
   logic [31:0] dst_q, dst_d;
   logic [15:0] rem_q, rem_d;
   logic [31:0] src_ip_q, src_ip_d;
   logic [15:0] payload_len_q, payload_len_d;
   logic        pkt_ok_q, pkt_ok_d;
   logic        drop_q, drop_d;
   logic [2:0]  drop_code_q, drop_code_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   logic        in_payload, hdr_st, acc, addr_ok, csum_clear;
   logic [5:0]  hdr_bytes, last_idx;
   logic [31:0] dst_cur;
   logic [2:0]  fail_code;
   logic [15:0] csum_sum;

   assign in_payload = (state_q == ST_PAYLOAD) && !reset;
   assign hdr_st     = (state_q == ST_HDR) || (state_q == ST_OPT);

   assign ip_axis_tready_out  = !reset && ((state_q == ST_PAYLOAD) ? udp_axis_tready_in : 1'b1);
   assign udp_axis_tvalid_out = in_payload && ip_axis_tvalid_in;
   assign udp_axis_tdata_out  = in_payload ? ip_axis_tdata_in : 8'h00;
   assign udp_axis_tlast_out  = in_payload && ((rem_q == 16'd1) || ip_axis_tlast_in);

   assign acc = ip_axis_tvalid_in && ip_axis_tready_out;

   assign hdr_bytes = {ver_ihl_q[3:0], 2'b00};
   // A bad IHL still waits for b19 so every decision lands at the same point.
   assign last_idx  = (ver_ihl_q[3:0] < 4'd5) ? 6'd19 : hdr_bytes - 6'd1;
   assign dst_cur   = (hdr_cnt_q == 6'd19) ? {dst_q[23:0], ip_axis_tdata_in} : dst_q;
   assign addr_ok   = (dst_cur == LOCAL_IP) || (ACCEPT_BCAST && (dst_cur == 32'hFFFF_FFFF));

   ip_csum_acc u_csum (
      .clk     (clk),
      .reset   (reset),
      .clear   (csum_clear),
      .en      (hdr_st && acc),
      .odd     (hdr_cnt_q[0]),
      .byte_in (ip_axis_tdata_in),
      .sum_out (csum_sum)
   );

   always_comb begin
      fail_code = DROP_NONE;
      if ((ver_ihl_q[7:4] != 4'd4) || (ver_ihl_q[3:0] < 4'd5))    fail_code = DROP_VER;
      else if (proto_q != IPV4_PROTO_UDP)                         fail_code = DROP_PROTO;
      else if (!addr_ok)                                          fail_code = DROP_ADDR;
      else if (mf_q || (frag_off_q != 13'd0))                     fail_code = DROP_FRAG;
      else if (tot_len_q < ({10'd0, hdr_bytes} + 16'd8))          fail_code = DROP_LEN;
      else if (CHECK_CSUM && (csum_sum != 16'hFFFF))              fail_code = DROP_CSUM;
   end

   always_comb begin
      state_d       = state_q;
      hdr_cnt_d     = hdr_cnt_q;
      ver_ihl_d     = ver_ihl_q;
      tot_len_d     = tot_len_q;
      mf_d          = mf_q;
      frag_off_d    = frag_off_q;
      proto_d       = proto_q;
      src_hdr_d     = src_hdr_q;
      dst_d         = dst_q;
      rem_d         = rem_q;
      src_ip_d      = src_ip_q;
      payload_len_d = payload_len_q;
      pkt_ok_d      = 1'b0;
      drop_d        = 1'b0;
      drop_code_d   = 3'd0;
      csum_clear    = !hdr_st;

      case (state_q)
         ST_HDR, ST_OPT: begin
            if (acc) begin
               hdr_cnt_d = hdr_cnt_q + 6'd1;
               case (hdr_cnt_q)
                  6'd0:                      ver_ihl_d = ip_axis_tdata_in;
                  6'd2, 6'd3:                tot_len_d = {tot_len_q[7:0], ip_axis_tdata_in};
                  6'd6: begin
                     mf_d              = ip_axis_tdata_in[5];
                     frag_off_d[12:8]  = ip_axis_tdata_in[4:0];
                  end
                  6'd7:                      frag_off_d[7:0] = ip_axis_tdata_in;
                  6'd9:                      proto_d = ip_axis_tdata_in;
                  6'd12, 6'd13, 6'd14, 6'd15: src_hdr_d = {src_hdr_q[23:0], ip_axis_tdata_in};
                  6'd16, 6'd17, 6'd18, 6'd19: dst_d = {dst_q[23:0], ip_axis_tdata_in};
                  default: ;
               endcase

               if (hdr_cnt_q == last_idx) begin
                  hdr_cnt_d  = 6'd0;
                  csum_clear = 1'b1;
                  if (fail_code != DROP_NONE) begin
                     drop_d      = 1'b1;
                     drop_code_d = fail_code;
                     state_d     = ip_axis_tlast_in ? ST_HDR : ST_DROP;
                  end else if (ip_axis_tlast_in) begin
                     // Good header but the frame ends before any payload.
                     drop_d      = 1'b1;
                     drop_code_d = DROP_TRUNC;
                     state_d     = ST_HDR;
                  end else begin
                     pkt_ok_d      = 1'b1;
                     src_ip_d      = src_hdr_q;
                     payload_len_d = tot_len_q - {10'd0, hdr_bytes};
                     rem_d         = tot_len_q - {10'd0, hdr_bytes};
                     state_d       = ST_PAYLOAD;
                  end
               end else if (ip_axis_tlast_in) begin
                  hdr_cnt_d   = 6'd0;
                  csum_clear  = 1'b1;
                  drop_d      = 1'b1;
                  drop_code_d = DROP_LEN;
                  state_d     = ST_HDR;
               end else if (hdr_cnt_q == 6'd19) begin
                  state_d = ST_OPT;
               end
            end
         end
         ST_PAYLOAD: begin
            if (acc) begin
               rem_d = rem_q - 16'd1;
               if (rem_q == 16'd1) begin
                  state_d = ip_axis_tlast_in ? ST_HDR : ST_DROP;
               end else if (ip_axis_tlast_in) begin
                  drop_d      = 1'b1;
                  drop_code_d = DROP_TRUNC;
                  state_d     = ST_HDR;
               end
            end
         end
         ST_DROP: begin
            if (ip_axis_tvalid_in && ip_axis_tlast_in) state_d = ST_HDR;
         end
         default: state_d = ST_HDR;
      endcase

      drop_cnt_d = (drop_d && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_HDR;
         hdr_cnt_q     <= 6'd0;
         ver_ihl_q     <= 8'h00;
         tot_len_q     <= 16'h0000;
         mf_q          <= 1'b0;
         frag_off_q    <= 13'd0;
         proto_q       <= 8'h00;
         src_hdr_q     <= 32'h0;
         dst_q         <= 32'h0;
         rem_q         <= 16'h0000;
         src_ip_q      <= 32'h0;
         payload_len_q <= 16'h0000;
         pkt_ok_q      <= 1'b0;
         drop_q        <= 1'b0;
         drop_code_q   <= 3'd0;
         drop_cnt_q    <= 16'h0000;
      end else begin
         state_q       <= state_d;
         hdr_cnt_q     <= hdr_cnt_d;
         ver_ihl_q     <= ver_ihl_d;
         tot_len_q     <= tot_len_d;
         mf_q          <= mf_d;
         frag_off_q    <= frag_off_d;
         proto_q       <= proto_d;
         src_hdr_q     <= src_hdr_d;
         dst_q         <= dst_d;
         rem_q         <= rem_d;
         src_ip_q      <= src_ip_d;
         payload_len_q <= payload_len_d;
         pkt_ok_q      <= pkt_ok_d;
         drop_q        <= drop_d;
         drop_code_q   <= drop_code_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   assign src_ip_out      = src_ip_q;
   assign payload_len_out = payload_len_q;
   assign pkt_ok_out      = pkt_ok_q;
   assign drop_out        = drop_q;
   assign drop_code_out   = drop_code_q;
   assign drop_cnt_out    = drop_cnt_q;

endmodule

// File: tb/tb_ipv4_rcv.sv
// Bench for ipv4_rcv: builds IPv4 frames, queues the expected payload bytes and
// header events, and compares them as the DUTs (checksum on / off) produce them.
module tb_ipv4_rcv;

   localparam logic [31:0] LOCAL = 32'hC0A8_0A02;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [7:0]  ip_tdata;
   logic        ip_tvalid, ip_tlast, ip_tready, ip_tready1;
   logic        udp_tready_in;
   logic [7:0]  udp_tdata, udp_tdata1;
   logic        udp_tvalid, udp_tvalid1, udp_tlast, udp_tlast1;
   logic [31:0] src_ip, src_ip1;
   logic [15:0] plen, plen1, drop_cnt, drop_cnt1;
   logic        pkt_ok, pkt_ok1, drop, drop1;
   logic [2:0]  drop_code, drop_code1;

   ipv4_rcv u_dut (
      .clk (clk), .reset (reset),
      .ip_axis_tdata_in (ip_tdata), .ip_axis_tvalid_in (ip_tvalid),
      .ip_axis_tlast_in (ip_tlast), .ip_axis_tready_out (ip_tready),
      .udp_axis_tdata_out (udp_tdata), .udp_axis_tvalid_out (udp_tvalid),
      .udp_axis_tlast_out (udp_tlast), .udp_axis_tready_in (udp_tready_in),
      .src_ip_out (src_ip), .payload_len_out (plen), .pkt_ok_out (pkt_ok),
      .drop_out (drop), .drop_code_out (drop_code), .drop_cnt_out (drop_cnt)
   );

   ipv4_rcv #(.CHECK_CSUM (1'b0)) u_dut_nocsum (
      .clk (clk), .reset (reset),
      .ip_axis_tdata_in (ip_tdata), .ip_axis_tvalid_in (ip_tvalid),
      .ip_axis_tlast_in (ip_tlast), .ip_axis_tready_out (ip_tready1),
      .udp_axis_tdata_out (udp_tdata1), .udp_axis_tvalid_out (udp_tvalid1),
      .udp_axis_tlast_out (udp_tlast1), .udp_axis_tready_in (udp_tready_in),
      .src_ip_out (src_ip1), .payload_len_out (plen1), .pkt_ok_out (pkt_ok1),
      .drop_out (drop1), .drop_code_out (drop_code1), .drop_cnt_out (drop_cnt1)
   );

   typedef struct packed {
      logic        is_drop;
      logic [2:0]  code;
      logic [15:0] plen;
      logic [31:0] src;
      logic [15:0] cnt;
   } ev_t;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [8:0]  exp_q[$];
   logic [8:0]  exp1_q[$];
   ev_t         ev_q[$];
   logic [7:0]  pkt[$];
   logic [7:0]  pay[$];
   logic [7:0]  hdr[60];
   logic [31:0] cur_src;
   int          pkt_no = 0;
   int          exp_drops = 0;
   bit          toggle_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   function automatic logic [15:0] hdr_csum(input int hl);
      logic [31:0] s;
      s = 32'd0;
      for (int i = 0; i < hl; i += 2) s += {16'd0, hdr[i], hdr[i+1]};
      while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      return ~s[15:0];
   endfunction

   task automatic build(input logic [7:0] vi, input logic [7:0] proto, input logic [31:0] dst,
                        input logic [15:0] ff, input int tot_len, input int n_pay,
                        input int n_pad, input bit bad);
      int          hl;
      logic [15:0] tl, cs;
      hl = 4 * int'(vi[3:0]);
      if (hl < 20) hl = 20;
      tl = tot_len[15:0];
      cur_src = 32'h0A00_0100 + pkt_no;
      pkt_no++;
      for (int i = 0; i < 60; i++) hdr[i] = 8'h00;
      hdr[0] = vi;          hdr[2] = tl[15:8];      hdr[3] = tl[7:0];
      hdr[4] = 8'h12;       hdr[5] = 8'h34;         hdr[6] = ff[15:8];  hdr[7] = ff[7:0];
      hdr[8] = 8'h40;       hdr[9] = proto;
      for (int i = 0; i < 4; i++) begin
         hdr[12+i] = cur_src[31-8*i -: 8];
         hdr[16+i] = dst[31-8*i -: 8];
      end
      for (int i = 20; i < hl; i++) hdr[i] = 8'hA0 + 8'(i);
      cs = hdr_csum(hl);
      hdr[10] = cs[15:8];
      hdr[11] = bad ? (cs[7:0] ^ 8'h01) : cs[7:0];
      pkt.delete();
      pay.delete();
      for (int i = 0; i < hl; i++) pkt.push_back(hdr[i]);
      for (int i = 0; i < n_pay; i++) begin
         pay.push_back(8'($urandom));
         pkt.push_back(pay[i]);
      end
      for (int i = 0; i < n_pad; i++) pkt.push_back(8'h00);
   endtask

   task automatic exp_bytes(input int n, input bit last, input bit to0, input bit to1);
      for (int i = 0; i < n; i++) begin
         if (to0) exp_q.push_back({last && (i == n - 1), pay[i]});
         if (to1) exp1_q.push_back({last && (i == n - 1), pay[i]});
      end
   endtask

   task automatic exp_ok(input int n);
      ev_q.push_back('{is_drop: 1'b0, code: 3'd0, plen: 16'(n), src: cur_src, cnt: 16'd0});
   endtask

   task automatic exp_drop(input logic [2:0] code);
      exp_drops++;
      ev_q.push_back('{is_drop: 1'b1, code: code, plen: 16'd0, src: 32'd0, cnt: 16'(exp_drops)});
   endtask

   // Sends pkt[0..n-1] with occasional idle cycles; tlast on index tl_idx.
   task automatic send(input int n, input int tl_idx);
      for (int i = 0; i < n; i++) begin
         bit hs;
         if ($urandom_range(0, 7) == 0) begin
            ip_tvalid = 1'b0;
            @(posedge clk); #1;
         end
         ip_tdata  = pkt[i];
         ip_tvalid = 1'b1;
         ip_tlast  = (i == tl_idx);
         hs = 1'b0;
         for (int w = 0; w < 100 && !hs; w++) begin
            @(negedge clk);
            hs = ip_tready;
            @(posedge clk); #1;
         end
         if (!hs) check("handshake_timeout", 32'd0, 32'd1);
      end
      ip_tvalid = 1'b0;
      ip_tlast  = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && (exp_q.size() + exp1_q.size() + ev_q.size()) != 0; i++)
         @(posedge clk);
      check("drain_pending", exp_q.size() + exp1_q.size() + ev_q.size(), 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic send_good(input int n_pay);
      build(8'h45, 8'd17, LOCAL, 16'h4000, 20 + n_pay, n_pay, 0, 1'b0);
      exp_ok(n_pay);
      exp_bytes(n_pay, 1'b1, 1'b1, 1'b1);
      send(pkt.size(), pkt.size() - 1);
      drain();
   endtask

   task automatic drop_case(input logic [7:0] vi, input logic [7:0] proto, input logic [31:0] dst,
                            input logic [15:0] ff, input int tl, input logic [2:0] code);
      build(vi, proto, dst, ff, tl, 8, 0, 1'b0);
      exp_drop(code);
      send(pkt.size(), pkt.size() - 1);
      drain();
      send_good(8 + $urandom_range(0, 8));
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         udp_tready_in = toggle_en ? ~udp_tready_in : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (udp_tvalid) check("ready_mirror", ip_tready, udp_tready_in);
         if (udp_tvalid && udp_tready_in) begin
            if (exp_q.size() == 0) check("unexpected_byte", {23'd0, udp_tlast, udp_tdata}, 32'h1FF);
            else check("byte", {23'd0, udp_tlast, udp_tdata}, {23'd0, exp_q.pop_front()});
         end
         if (udp_tvalid1 && udp_tready_in) begin
            if (exp1_q.size() == 0)
               check("unexpected_byte_nocsum", {23'd0, udp_tlast1, udp_tdata1}, 32'h1FF);
            else check("byte_nocsum", {23'd0, udp_tlast1, udp_tdata1}, {23'd0, exp1_q.pop_front()});
         end
         if (pkt_ok || drop) begin
            if (ev_q.size() == 0) begin
               check("unexpected_event", {29'd0, drop, drop_code}, 32'hFFFF);
            end else begin
               ev_t e;
               e = ev_q.pop_front();
               check("event_kind", {31'd0, drop}, {31'd0, e.is_drop});
               check("event_single", {31'd0, pkt_ok & drop}, 32'd0);
               if (e.is_drop) begin
                  check("drop_code", {29'd0, drop_code}, {29'd0, e.code});
                  check("drop_cnt", {16'd0, drop_cnt}, {16'd0, e.cnt});
               end else begin
                  check("payload_len", {16'd0, plen}, {16'd0, e.plen});
                  check("src_ip", src_ip, e.src);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      ip_tvalid = 1'b0;
      ip_tlast  = 1'b0;
      ip_tdata  = 8'h00;
      udp_tready_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", {31'd0, udp_tvalid}, 32'd0);
      check("rst_tready", {31'd0, ip_tready}, 32'd0);
      check("rst_pulses", {30'd0, pkt_ok, drop}, 32'd0);
      check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("idle_tready", {31'd0, ip_tready}, 32'd1);
      @(posedge clk); #1;

      // Basic 16-byte datagram.
      build(8'h45, 8'd17, LOCAL, 16'h0000, 36, 16, 0, 1'b0);
      exp_ok(16);
      exp_bytes(16, 1'b1, 1'b1, 1'b1);
      send(pkt.size(), pkt.size() - 1);
      drain();

      // Corrupt checksum: dropped here, forwarded by the checksum-blind instance.
      build(8'h45, 8'd17, LOCAL, 16'h0000, 36, 16, 0, 1'b1);
      exp_drop(3'd6);
      exp_bytes(16, 1'b1, 1'b0, 1'b1);
      send(pkt.size(), pkt.size() - 1);
      drain();
      check("drop_cnt_after_csum", {16'd0, drop_cnt}, 32'd1);

      drop_case(8'h45, 8'd6,  LOCAL,         16'h0000, 28, 3'd2);
      drop_case(8'h45, 8'd17, 32'hC0A80A03,  16'h0000, 28, 3'd3);
      drop_case(8'h45, 8'd17, LOCAL,         16'h2000, 28, 3'd4);
      drop_case(8'h45, 8'd17, LOCAL,         16'h0001, 28, 3'd4);
      drop_case(8'h65, 8'd17, LOCAL,         16'h0000, 28, 3'd1);
      drop_case(8'h44, 8'd17, LOCAL,         16'h0000, 28, 3'd1);
      drop_case(8'h45, 8'd6,  32'hC0A80A03,  16'h0000, 28, 3'd2);
      drop_case(8'h45, 8'd17, LOCAL,         16'h0000, 27, 3'd5);

      // Broadcast destination accepted.
      build(8'h45, 8'd17, 32'hFFFF_FFFF, 16'h0000, 30, 10, 0, 1'b0);
      exp_ok(10);
      exp_bytes(10, 1'b1, 1'b1, 1'b1);
      send(pkt.size(), pkt.size() - 1);
      drain();

      // One option word, 8-byte payload, padded to a 46-byte Ethernet payload.
      build(8'h46, 8'd17, LOCAL, 16'h0000, 32, 8, 14, 1'b0);
      exp_ok(8);
      exp_bytes(8, 1'b1, 1'b1, 1'b1);
      send(pkt.size(), pkt.size() - 1);
      drain();
      check("drop_cnt_after_pad", {16'd0, drop_cnt}, exp_drops);

      // Downstream backpressure alternating every cycle.
      toggle_en = 1'b1;
      send_good(16);
      toggle_en = 1'b0;

      // Frame ends inside the header.
      build(8'h45, 8'd17, LOCAL, 16'h0000, 36, 16, 0, 1'b0);
      exp_drop(3'd5);
      send(10, 9);
      drain();
      send_good(9);

      // Frame ends after 5 of 16 payload bytes.
      build(8'h45, 8'd17, LOCAL, 16'h0000, 36, 5, 0, 1'b0);
      exp_ok(16);
      exp_drop(3'd7);
      exp_bytes(5, 1'b1, 1'b1, 1'b1);
      send(pkt.size(), pkt.size() - 1);
      drain();

      // Reset in the middle of a payload.
      build(8'h45, 8'd17, LOCAL, 16'h0000, 36, 16, 0, 1'b0);
      exp_ok(16);
      exp_bytes(6, 1'b0, 1'b1, 1'b1);
      send(26, -1);
      drain();
      reset = 1'b1;
      exp_drops = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("mid_rst_tvalid", {31'd0, udp_tvalid}, 32'd0);
      check("mid_rst_tready", {31'd0, ip_tready}, 32'd0);
      check("mid_rst_plen", {16'd0, plen}, 32'd0);
      check("mid_rst_src", src_ip, 32'd0);
      check("mid_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      send_good(12);
      drop_case(8'h45, 8'd6, LOCAL, 16'h0000, 28, 3'd2);

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
